// File: rtl/thumbs_pkg.sv
// Shared lane state type, widths and the saturating counter helper for auto_thumbs.
package thumbs_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned COL_W     = 5;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned TMR_W     = 4;
    localparam int unsigned INC_W     = $clog2(NUM_LANES + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PRESS,
        GAP
    } lane_state_t;

    // Add a per-cycle increment to a counter, clamping at all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [INC_W-1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, base} + (CNT_W + 1)'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/auto_lane.sv
// One autoplay lane: rising-edge note detect, hit delay, key press and release gap.
module auto_lane
    import thumbs_pkg::*;
#(
    parameter int unsigned HIT_DELAY    = 1,
    parameter int unsigned PRESS_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic skip,
    input  logic col_bit,
    output logic key_n,
    output logic busy,
    output logic press,
    output logic drop
);

    localparam logic [TMR_W-1:0] PRESS_LOAD  = TMR_W'(PRESS_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD    = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] WAIT_LOAD   = TMR_W'((HIT_DELAY == 0) ? 0 : HIT_DELAY - 1);
    localparam bit               DIRECT      = (HIT_DELAY == 0);
    localparam lane_state_t      START_STATE = DIRECT ? PRESS : WAIT;
    localparam logic [TMR_W-1:0] START_LOAD  = DIRECT ? PRESS_LOAD : WAIT_LOAD;

    lane_state_t      state;
    logic [TMR_W-1:0] timer;
    logic             prev;
    logic             note_edge;
    logic             pending;
    logic             note_c;
    logic             gap_done_c;
    logic             launch_c;
    logic             queue_c;
    logic             drop_c;

    // A note arriving on the last gap cycle starts straight away instead of queueing.
    always_comb begin
        note_c     = note_edge && enable && !skip;
        gap_done_c = (state == GAP) && (timer == '0);
        launch_c   = ((state == IDLE) && note_c) ||
                     (gap_done_c && enable && (pending || note_c));
        queue_c    = note_c && (state != IDLE) && !gap_done_c;
        drop_c     = note_c && pending && (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            prev      <= 1'b0;
            note_edge <= 1'b0;
            pending   <= 1'b0;
            key_n     <= 1'b1;
            busy      <= 1'b0;
            press     <= 1'b0;
            drop      <= 1'b0;
        end else begin
            prev      <= col_bit;
            note_edge <= col_bit && !prev;
            press     <= 1'b0;
            drop      <= drop_c;

            if (!enable || gap_done_c) begin
                pending <= 1'b0;
            end else if (queue_c) begin
                pending <= 1'b1;
            end

            if (launch_c) begin
                state <= START_STATE;
                timer <= START_LOAD;
                key_n <= !DIRECT;
                press <= DIRECT;
                busy  <= 1'b1;
            end else begin
                case (state)
                    WAIT: begin
                        if (!enable) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (timer == '0) begin
                            state <= PRESS;
                            timer <= PRESS_LOAD;
                            key_n <= 1'b0;
                            press <= 1'b1;
                        end else begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    PRESS: begin
                        if (timer == '0) begin
                            state <= GAP;
                            timer <= GAP_LOAD;
                            key_n <= 1'b1;
                        end else begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    GAP: begin
                        if (timer == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/auto_thumbs.sv
// Four-lane rhythm-game autoplayer driving active-low keys, with press/drop counters.
// Build option AUTO_THUMBS_MISS_EN adds an 8-bit LFSR that makes lanes skip some notes.
module auto_thumbs
    import thumbs_pkg::*;
#(
    parameter int unsigned HIT_DELAY    = 1,
    parameter int unsigned PRESS_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [COL_W-1:0]     column1,
    input  logic [COL_W-1:0]     column2,
    input  logic [COL_W-1:0]     column3,
    input  logic [COL_W-1:0]     column4,
    output logic [NUM_LANES-1:0] keys_n,
    output logic [CNT_W-1:0]     press_count,
    output logic [CNT_W-1:0]     drop_count,
    output logic                 busy
);

    logic [NUM_LANES-1:0] col_bits;
    logic [NUM_LANES-1:0] lane_busy;
    logic [NUM_LANES-1:0] lane_press;
    logic [NUM_LANES-1:0] lane_drop;
    logic [INC_W-1:0]     press_inc_c;
    logic [INC_W-1:0]     drop_inc_c;
    logic                 skip_c;
    logic                 unused_cols;

    // Only the target row of each column matters; the rest of the LED column is ignored.
    assign col_bits    = {column4[0], column3[0], column2[0], column1[0]};
    assign unused_cols = ^{column1[COL_W-1:1], column2[COL_W-1:1],
                           column3[COL_W-1:1], column4[COL_W-1:1]};
    assign busy        = |lane_busy;

`ifdef AUTO_THUMBS_MISS_EN
    logic [7:0] lfsr;

    // x^8 + x^6 + x^5 + x^4 + 1, free-running from reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'h01;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign skip_c = (lfsr[2:0] == 3'b000);
`else
    assign skip_c = 1'b0;
`endif

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        auto_lane #(
            .HIT_DELAY   (HIT_DELAY),
            .PRESS_CYCLES(PRESS_CYCLES),
            .GAP_CYCLES  (GAP_CYCLES)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .enable (enable),
            .skip   (skip_c),
            .col_bit(col_bits[i]),
            .key_n  (keys_n[i]),
            .busy   (lane_busy[i]),
            .press  (lane_press[i]),
            .drop   (lane_drop[i])
        );
    end

    always_comb begin
        press_inc_c = '0;
        drop_inc_c  = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            press_inc_c = press_inc_c + INC_W'(lane_press[i]);
            drop_inc_c  = drop_inc_c + INC_W'(lane_drop[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_count <= '0;
            drop_count  <= '0;
        end else begin
            press_count <= sat_add(press_count, press_inc_c);
            drop_count  <= sat_add(drop_count, drop_inc_c);
        end
    end

endmodule

// File: tb/tb_auto_thumbs.sv
// Bench for auto_thumbs: a note-scheduling model checked every cycle plus directed literals.
// Define AUTO_THUMBS_MISS_EN for both bench and RTL to exercise the note-skip LFSR.
module tb_auto_thumbs;

    localparam int D = 1;
    localparam int P = 2;
    localparam int G = 1;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       enable  = 1'b1;
    logic [4:0] column1 = '0;
    logic [4:0] column2 = '0;
    logic [4:0] column3 = '0;
    logic [4:0] column4 = '0;
    logic [3:0] keys_n;
    logic [7:0] press_count;
    logic [7:0] drop_count;
    logic       busy;

    auto_thumbs #(
        .HIT_DELAY   (D),
        .PRESS_CYCLES(P),
        .GAP_CYCLES  (G)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .column1    (column1),
        .column2    (column2),
        .column3    (column3),
        .column4    (column4),
        .keys_n     (keys_n),
        .press_count(press_count),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;

    // Model: each lane holds at most one scheduled press (start edge st) and one queued note.
    bit         job    [4];
    bit         pend   [4];
    int         st     [4];
    bit         prev_m [4];
    bit         edge_m [4];
    int         m_press = 0;
    int         m_drop  = 0;
    int         add_p   = 0;
    int         add_d   = 0;
    logic [3:0] m_keys  = 4'hF;
    bit         m_busy  = 1'b0;
    logic [7:0] lfsr_m  = 8'h01;
    int         np;
    int         nd;
    bit         note_m;
    bit         skip_m;
    logic [3:0] colv;

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 4; l++) begin
                job[l] = 0; pend[l] = 0; st[l] = 0; prev_m[l] = 0; edge_m[l] = 0;
            end
            m_press = 0; m_drop = 0; add_p = 0; add_d = 0;
            m_keys = 4'hF; m_busy = 0; lfsr_m = 8'h01;
        end else begin
            cyc++;
            m_press = sat(m_press + add_p);
            m_drop  = sat(m_drop + add_d);
            np = 0; nd = 0; m_busy = 0;
            colv = {column4[0], column3[0], column2[0], column1[0]};
            skip_m = 0;
`ifdef AUTO_THUMBS_MISS_EN
            skip_m = (lfsr_m % 8 == 0);
            lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`endif
            for (int l = 0; l < 4; l++) begin
                note_m = edge_m[l] && enable && !skip_m;
                if (!enable) begin
                    pend[l] = 0;
                    if (job[l] && cyc > st[l] - D && cyc <= st[l]) job[l] = 0;
                end
                if (!job[l]) begin
                    if (note_m) begin job[l] = 1; st[l] = cyc + D; end
                end else if (cyc == st[l] + P + G) begin
                    if (pend[l] || note_m) begin
                        if (pend[l] && note_m) nd++;
                        pend[l] = 0;
                        st[l] = cyc + D;
                    end else begin
                        job[l] = 0;
                    end
                end else if (note_m) begin
                    if (pend[l]) nd++;
                    else pend[l] = 1;
                end
                if (job[l] && st[l] == cyc) np++;
                m_keys[l] = !(job[l] && cyc >= st[l] && cyc < st[l] + P);
                m_busy    = m_busy | job[l];
                edge_m[l] = colv[l] && !prev_m[l];
                prev_m[l] = colv[l];
            end
            add_p = np;
            add_d = nd;
        end
    end

    always @(negedge clk) begin
        chk("keys_n", int'(keys_n), int'(m_keys));
        chk("busy", int'(busy), int'(m_busy));
        chk("press_count", int'(press_count), m_press);
        chk("drop_count", int'(drop_count), m_drop);
    end

    // One-cycle note on the lanes in m, then idle cycles so the lanes settle.
    task automatic note(input logic [3:0] m, input int idle);
        column1 = {4'b1011, m[0]};
        column2 = {4'b0110, m[1]};
        column3 = {4'b1100, m[2]};
        column4 = {4'b0001, m[3]};
        @(negedge clk);
        column1 = 5'b10100;
        column2 = 5'b00010;
        column3 = 5'b01000;
        column4 = 5'b11110;
        repeat (idle) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_keys", int'(keys_n), 15);
        chk("reset_press", int'(press_count), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single note on lane 1: low after edges 2 and 3.
        column1 = 5'b00001;
        @(negedge clk);
        chk("one_e0_keys", int'(keys_n), 15);
        column1 = 5'b00000;
        @(negedge clk);
        chk("one_e1_keys", int'(keys_n), 15);
        chk("one_e1_busy", int'(busy), 1);
        @(negedge clk);
        chk("one_e2_keys", int'(keys_n), 14);
        @(negedge clk);
        chk("one_e3_keys", int'(keys_n), 14);
        chk("one_e3_press", int'(press_count), 1);
        @(negedge clk);
        chk("one_e4_keys", int'(keys_n), 15);
        chk("one_e4_busy", int'(busy), 1);
        @(negedge clk);
        chk("one_e5_busy", int'(busy), 0);

        // All four lanes together.
        column1 = 5'b00001; column2 = 5'b00001; column3 = 5'b00001; column4 = 5'b00001;
        @(negedge clk);
        column1 = '0; column2 = '0; column3 = '0; column4 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("all_e2_keys", int'(keys_n), 0);
        @(negedge clk);
        chk("all_e3_keys", int'(keys_n), 0);
        chk("all_e3_press", int'(press_count), 5);
        @(negedge clk);
        chk("all_e4_keys", int'(keys_n), 15);
        repeat (2) @(negedge clk);

        // Three lane-2 notes: one played, one queued, one dropped.
        for (int i = 0; i < 6; i++) begin
            column2 = {4'b0000, 1'(i % 2 == 0)};
            @(negedge clk);
        end
        column2 = '0;
        repeat (8) @(negedge clk);
        chk("train_drop", int'(drop_count), 1);
        chk("train_press", int'(press_count), 7);

        // Reset mid-press; column1 held high across release counts as a fresh note.
        column1 = 5'b00001;
        repeat (3) @(negedge clk);
        chk("pre_reset_keys", int'(keys_n), 14);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_keys", int'(keys_n), 15);
        chk("async_rst_press", int'(press_count), 0);
        chk("async_rst_drop", int'(drop_count), 0);
        chk("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        column1 = '0;
        repeat (2) @(negedge clk);
        chk("first_after_reset", int'(keys_n), 14);
        repeat (4) @(negedge clk);

        // Enable dropped while lane 3 waits: the note is abandoned.
        column3 = 5'b00001;
        @(negedge clk);
        column3 = '0;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("cancel_keys", int'(keys_n), 15);
        chk("cancel_busy", int'(busy), 0);
        @(negedge clk);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        chk("cancel_press", int'(press_count), 1);

        for (int i = 0; i < 64; i++) note(4'b0001, 6);
`ifndef AUTO_THUMBS_MISS_EN
        chk("sixty_four", int'(press_count), 65);
`endif
        for (int i = 0; i < 47; i++) note(4'b1111, 6);
        note(4'b0001, 6);
`ifndef AUTO_THUMBS_MISS_EN
        chk("press_254", int'(press_count), 254);
`endif
        for (int i = 0; i < 3; i++) note(4'b0001, 6);
`ifndef AUTO_THUMBS_MISS_EN
        chk("press_sat", int'(press_count), 255);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
